// File: rtl/vram_pkg.sv
// Shared types and helpers for the VRAM arbiter and its access sequencer.
package vram_pkg;

  localparam int VRAM_AW = 18;
  localparam int VRAM_DW = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_STB,
    ST_WR_SETUP,
    ST_WR_STB,
    ST_WR_REC
  } seq_state_t;

  // Byte enables are active high, SRAM dqm is active high "lane disabled".
  function automatic logic [1:0] lane_to_dqm(input logic [1:0] lane);
    return ~lane;
  endfunction

endpackage

// File: rtl/vram_access_seq.sv
// Strobe/timing sequencer for one asynchronous SRAM access; every pin and
// completion output is a flop driven from the next-state decode.
module vram_access_seq
  import vram_pkg::*;
#(
  parameter int ADDR_WIDTH    = VRAM_AW,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  start_we,
  input  logic                  start_cpu,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [VRAM_DW-1:0]    start_wdata,
  input  logic [1:0]            start_lane,
  output logic                  idle,
  output logic                  vid_done,
  output logic                  cpu_done,
  output logic [VRAM_DW-1:0]    vid_rdata,
  output logic [VRAM_DW-1:0]    cpu_rdata,
  output logic [ADDR_WIDTH-1:0] vram_a,
  output logic [VRAM_DW-1:0]    vram_d_o,
  input  logic [VRAM_DW-1:0]    vram_d_i,
  output logic                  vram_d_oe,
  output logic [1:0]            vram_dqm,
  output logic                  vram_cs_n,
  output logic                  vram_we_n,
  output logic                  vram_oe_n
);

  localparam int CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYCLES - 1);

  seq_state_t       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             owner_cpu_reg;
  logic             rd_last, wr_last;

  assign idle    = (state_reg == ST_IDLE);
  assign rd_last = (state_reg == ST_RD_STB) && (cnt_reg == CNT_LAST);
  assign wr_last = (state_reg == ST_WR_STB) && (cnt_reg == CNT_LAST);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next = start_we ? ST_WR_SETUP : ST_RD_STB;
          cnt_next   = '0;
        end
      end
      ST_RD_STB: begin
        if (rd_last) state_next = ST_IDLE;
        else         cnt_next   = cnt_reg + 1'b1;
      end
      ST_WR_SETUP: begin
        state_next = ST_WR_STB;
        cnt_next   = '0;
      end
      ST_WR_STB: begin
        if (wr_last) state_next = ST_WR_REC;
        else         cnt_next   = cnt_reg + 1'b1;
      end
      ST_WR_REC: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      owner_cpu_reg <= 1'b0;
      vram_cs_n     <= 1'b1;
      vram_we_n     <= 1'b1;
      vram_oe_n     <= 1'b1;
      vram_dqm      <= 2'b11;
      vram_d_oe     <= 1'b0;
      vram_a        <= '0;
      vram_d_o      <= '0;
      vid_done      <= 1'b0;
      cpu_done      <= 1'b0;
      vid_rdata     <= '0;
      cpu_rdata     <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      // Strobes are decoded from the next state so they change exactly on state edges.
      vram_cs_n <= (state_next == ST_IDLE);
      vram_oe_n <= (state_next != ST_RD_STB);
      vram_we_n <= (state_next != ST_WR_STB);
      vram_d_oe <= (state_next inside {ST_WR_SETUP, ST_WR_STB, ST_WR_REC});
      if (idle && start) begin
        vram_a        <= start_addr;
        vram_d_o      <= start_wdata;
        vram_dqm      <= start_we ? lane_to_dqm(start_lane) : 2'b00;
        owner_cpu_reg <= start_cpu;
      end else if (state_next == ST_IDLE) begin
        vram_dqm <= 2'b11;
      end
      vid_done <= rd_last && !owner_cpu_reg;
      cpu_done <= (rd_last && owner_cpu_reg) || wr_last;
      if (rd_last) begin
        if (owner_cpu_reg) cpu_rdata <= vram_d_i;
        else               vid_rdata <= vram_d_i;
      end
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// Shares one asynchronous VRAM between video scanout and the CPU bus: video
// has priority, a starvation counter forces a CPU grant after a video run.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int ADDR_WIDTH     = VRAM_AW,
  parameter int ACCESS_CYCLES  = 2,
  parameter int CPU_STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  vid_req,
  input  logic [ADDR_WIDTH-1:0] vid_addr,
  output logic                  vid_ack,
  output logic [VRAM_DW-1:0]    vid_rdata,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [VRAM_DW-1:0]    cpu_wdata,
  input  logic [1:0]            cpu_lane,
  output logic                  cpu_ack,
  output logic [VRAM_DW-1:0]    cpu_rdata,
  output logic [ADDR_WIDTH-1:0] vram_a,
  output logic [VRAM_DW-1:0]    vram_d_o,
  input  logic [VRAM_DW-1:0]    vram_d_i,
  output logic                  vram_d_oe,
  output logic [1:0]            vram_dqm,
  output logic                  vram_cs_n,
  output logic                  vram_we_n,
  output logic                  vram_oe_n
);

  localparam int SW = $clog2(CPU_STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(CPU_STARVE_MAX);

  logic [SW-1:0] starve_cnt_reg, starve_cnt_next;
  logic          seq_idle, vid_wins, grant_vid, grant_cpu;

  // Priority is decided on the raw requests; a requester still acking this
  // cycle wins nothing, so a held video request cannot hand CPU a free slot.
  always_comb begin
    vid_wins  = vid_req && !(cpu_req && (starve_cnt_reg == STARVE_MAX));
    grant_vid = seq_idle && vid_wins && !vid_ack;
    grant_cpu = seq_idle && !vid_wins && cpu_req && !cpu_ack;
    starve_cnt_next = starve_cnt_reg;
    if (!cpu_req || grant_cpu)
      starve_cnt_next = '0;
    else if (grant_vid && (starve_cnt_reg != STARVE_MAX))
      starve_cnt_next = starve_cnt_reg + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) starve_cnt_reg <= '0;
    else       starve_cnt_reg <= starve_cnt_next;
  end

  vram_access_seq #(
    .ADDR_WIDTH    (ADDR_WIDTH),
    .ACCESS_CYCLES (ACCESS_CYCLES)
  ) u_seq (
    .clk         (clk),
    .reset       (reset),
    .start       (grant_vid || grant_cpu),
    .start_we    (grant_cpu && cpu_we),
    .start_cpu   (grant_cpu),
    .start_addr  (grant_cpu ? cpu_addr : vid_addr),
    .start_wdata (cpu_wdata),
    .start_lane  (cpu_lane),
    .idle        (seq_idle),
    .vid_done    (vid_ack),
    .cpu_done    (cpu_ack),
    .vid_rdata   (vid_rdata),
    .cpu_rdata   (cpu_rdata),
    .vram_a      (vram_a),
    .vram_d_o    (vram_d_o),
    .vram_d_i    (vram_d_i),
    .vram_d_oe   (vram_d_oe),
    .vram_dqm    (vram_dqm),
    .vram_cs_n   (vram_cs_n),
    .vram_we_n   (vram_we_n),
    .vram_oe_n   (vram_oe_n)
  );

endmodule
